// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup, EX resolve and statistics signals of the branch predictor
interface branch_predictor_if #(
    parameter int PC_WIDTH   = 32,
    parameter int STAT_WIDTH = 32
);
    logic [PC_WIDTH-1:0]   if_pc;
    logic                  pred_taken;
    logic [PC_WIDTH-1:0]   pred_target;
    logic                  ex_valid;
    logic [PC_WIDTH-1:0]   ex_pc;
    logic                  ex_taken;
    logic [PC_WIDTH-1:0]   ex_target;
    logic                  ex_pred_taken;
    logic [PC_WIDTH-1:0]   ex_pred_target;
    logic                  ex_mispredict;
    logic [PC_WIDTH-1:0]   ex_redirect_pc;
    logic [STAT_WIDTH-1:0] stat_branches;
    logic [STAT_WIDTH-1:0] stat_mispredicts;

    modport master (
        output if_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, ex_mispredict, ex_redirect_pc,
               stat_branches, stat_mispredicts
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, ex_mispredict, ex_redirect_pc,
               stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters, combinational lookup, registered training
module branch_predictor #(
    parameter int ENTRIES    = 64,
    parameter int PC_WIDTH   = 32,
    parameter int STAT_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    branch_predictor_if.slave   bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_WIDTH - IDX_W - 2;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    logic                  valid_q  [ENTRIES];
    logic                  valid_d  [ENTRIES];
    logic [TAG_W-1:0]      tag_q    [ENTRIES];
    logic [TAG_W-1:0]      tag_d    [ENTRIES];
    logic [PC_WIDTH-1:0]   target_q [ENTRIES];
    logic [PC_WIDTH-1:0]   target_d [ENTRIES];
    ctr_t                  ctr_q    [ENTRIES];
    ctr_t                  ctr_d    [ENTRIES];
    logic [STAT_WIDTH-1:0] stat_br_q, stat_br_d;
    logic [STAT_WIDTH-1:0] stat_mp_q, stat_mp_d;

    logic [IDX_W-1:0]      if_idx, ex_idx;
    logic [TAG_W-1:0]      if_tag, ex_tag;
    logic                  if_hit, ex_hit;
    logic [PC_WIDTH-1:0]   redirect_pc;
    logic                  mispredict;
    logic                  unused_pred_taken;

    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        ctr_t n;
        case (c)
            SNT:     n = taken ? WNT : SNT;
            WNT:     n = taken ? WT  : SNT;
            WT:      n = taken ? ST  : WNT;
            default: n = taken ? ST  : WT;
        endcase
        return n;
    endfunction

    // Lookup reads only the registered table, so a same-cycle update is not bypassed.
    assign if_idx         = bp.if_pc[IDX_W+1:2];
    assign if_tag         = bp.if_pc[PC_WIDTH-1:IDX_W+2];
    assign if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign bp.pred_taken  = if_hit && ctr_q[if_idx][1];
    assign bp.pred_target = bp.pred_taken ? target_q[if_idx] : bp.if_pc + PC_WIDTH'(4);

    // Comparing full next-PCs catches both wrong direction and stale taken targets.
    assign ex_idx            = bp.ex_pc[IDX_W+1:2];
    assign ex_tag            = bp.ex_pc[PC_WIDTH-1:IDX_W+2];
    assign ex_hit            = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign redirect_pc       = bp.ex_taken ? bp.ex_target : bp.ex_pc + PC_WIDTH'(4);
    assign mispredict        = bp.ex_valid && (bp.ex_pred_target != redirect_pc);
    assign bp.ex_redirect_pc = redirect_pc;
    assign bp.ex_mispredict  = mispredict;

    assign bp.stat_branches    = stat_br_q;
    assign bp.stat_mispredicts = stat_mp_q;
    assign unused_pred_taken   = bp.ex_pred_taken;

    always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        target_d  = target_q;
        ctr_d     = ctr_q;
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (bp.ex_valid) begin
            stat_br_d = stat_br_q + STAT_WIDTH'(1);
            if (mispredict) begin
                stat_mp_d = stat_mp_q + STAT_WIDTH'(1);
            end
            if (ex_hit) begin
                ctr_d[ex_idx] = ctr_next(ctr_q[ex_idx], bp.ex_taken);
                if (bp.ex_taken) begin
                    target_d[ex_idx] = bp.ex_target;
                end
            end else if (bp.ex_taken) begin
                valid_d[ex_idx]  = 1'b1;
                tag_d[ex_idx]    = ex_tag;
                target_d[ex_idx] = bp.ex_target;
                ctr_d[ex_idx]    = WT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WNT;
            end
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            valid_q   <= valid_d;
            tag_q     <= tag_d;
            target_q  <= target_d;
            ctr_q     <= ctr_d;
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end
endmodule
